cle_sram_arb: RTL and testbench
===============================

// Module: cle_sram_arb
// PURPOSE
//  Two-requester arbiter for the single-port 1024x8 label SRAM used by the connected-component labeling engine.
//  Port 0 is the labeler (neighbour reads, label writes); port 1 is the label-merge/readout pass.
//  Grants one access per cycle, drives the SRAM pins registered, and returns tagged read data to the issuer.
//  Lock lets the owner run an uninterrupted read-modify-write burst.
// PARAMETERS
//  AW        10  SRAM address width
//  DW        8   SRAM data width
//  RD_LAT    1   cycles from sram_a valid to sram_q valid (>=1)
//  BURST_MAX 8   max cycles a lock may be held before forced release (>=2)
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-high
//  r0_req     in   1   port 0 access request
//  r0_we      in   1   1 = write, 0 = read
//  r0_addr    in   AW  port 0 address
//  r0_wdata   in   DW  port 0 write data
//  r0_lock    in   1   keep ownership after this beat
//  r0_gnt     out  1   beat accepted this cycle (accepted = req & gnt)
//  r0_rvalid  out  1   r0_rdata valid (one-cycle pulse per read)
//  r0_rdata   out  DW  read data for port 0
//  r1_*       --   --  identical set for port 1
//  sram_a     out  AW  SRAM address (registered)
//  sram_d     out  DW  SRAM write data (registered)
//  sram_wen   out  1   SRAM write enable, active-low (registered)
//  sram_q     in   DW  SRAM read data
//  lock_err   out  1   one-cycle pulse on forced lock release
// BEHAVIOUR
//  Reset values: sram_a=0, sram_d=0, sram_wen=1, r*_gnt=0, r*_rvalid=0, r*_rdata=0, lock_err=0; FSM=IDLE, rr_ptr=0 (port 0 favoured).
//  gnt is combinational from req/FSM/rr_ptr; at most one gnt per cycle; gnt never high without req.
//  Issue: accept in cycle T -> sram_a/sram_d/sram_wen carry that beat in T+1. Cycles without an accept: sram_wen=1, sram_a/sram_d hold.
//  Read return: sram_q sampled RD_LAT cycles after T+1, registered into rdata; rvalid pulses in T+2+RD_LAT (T+3 at default).
//  Tag pipe: RD_LAT+1 deep {valid,id}; one read returns per cycle, in issue order; no reordering.
//  Writes return nothing. Issue order equals SRAM order, so write-then-read to the same address reads the new value. No forwarding.
//  FSM:
//   IDLE: one req -> grant it. Both -> grant port rr_ptr; after any accepted beat rr_ptr = other port.
//         Accepted beat with lock=1 -> OWNn, lock_cnt=0.
//   OWNn: only port n may be granted. Accepted beat with lock=0 -> IDLE.
//         lock_cnt increments every cycle in OWNn and clears on an accepted beat.
//         When lock_cnt reaches BURST_MAX-1: force IDLE, pulse lock_err, rr_ptr = other port.
//  Continuous requests from both ports with no lock: grants alternate every cycle, 100% SRAM utilisation.
//  Reset mid-operation: tag pipe flushed, no rvalid after release for pre-reset reads, lock dropped.
// TESTING
//  1 r0 read 0x155, SRAM holds 0x3C -> r0_gnt in T; sram_a=0x155, wen=1 in T+1; r0_rvalid=1, r0_rdata=0x3C in T+3.
//  2 r0,r1 both req continuously from first cycle after reset -> grants r0,r1,r0,r1...; rvalid order matches.
//  3 r0 4-beat burst (lock 1,1,1,0), r1 req held -> r1_gnt=0 until cycle after r0's 4th beat, then r1 granted.
//  4 r0 lock=1 beat then r0_req=0, r1 req -> lock_err pulses once after 8 cycles; r1_gnt in the next cycle.
//  5 r1 write 0x2A @0x3FF, then r1 read 0x3FF -> r1_rdata=0x2A; sram_wen low in exactly one cycle.
//  6 assert reset with 2 reads in flight -> all outputs at reset values; no rvalid after release; next req granted normally.

Source files
------------

// File: rtl/cle_sram_arb.sv
// cle_sram_arb: two-requester arbiter for the CCL engine's single-port label SRAM.
// Port 0 is the labeler, port 1 the merge/readout pass. One beat is accepted per
// cycle, driven onto registered SRAM pins, and read data returns tagged to its issuer.
module cle_sram_arb #(
   parameter int AW        = 10,
   parameter int DW        = 8,
   parameter int RD_LAT    = 1,
   parameter int BURST_MAX = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          r0_req,
   input  logic          r0_we,
   input  logic [AW-1:0] r0_addr,
   input  logic [DW-1:0] r0_wdata,
   input  logic          r0_lock,
   output logic          r0_gnt,
   output logic          r0_rvalid,
   output logic [DW-1:0] r0_rdata,
   input  logic          r1_req,
   input  logic          r1_we,
   input  logic [AW-1:0] r1_addr,
   input  logic [DW-1:0] r1_wdata,
   input  logic          r1_lock,
   output logic          r1_gnt,
   output logic          r1_rvalid,
   output logic [DW-1:0] r1_rdata,
   output logic [AW-1:0] sram_a,
   output logic [DW-1:0] sram_d,
   output logic          sram_wen,
   input  logic [DW-1:0] sram_q,
   output logic          lock_err
);

   localparam int            CW       = $clog2(BURST_MAX);
   localparam logic [CW-1:0] CNT_LAST = CW'(BURST_MAX - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            rr_ptr;     // 0: port 0 wins a tie, 1: port 1 wins
   logic [CW-1:0]   lock_cnt;   // idle cycles of the current lock owner

   logic            acc0;
   logic            acc1;
   logic            acc;
   logic            iss_we;
   logic [AW-1:0]   iss_addr;
   logic [DW-1:0]   iss_wdata;
   logic            rd_issue;

   // Read tags: bit 0 is the beat issued last cycle, bit RD_LAT the one whose data is on sram_q now.
   logic [RD_LAT:0] tag_vld;
   logic [RD_LAT:0] tag_id;

   // Grant and forced-release decode from requests, ownership state and round-robin pointer.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves one unassigned and infers a latch.
      r0_gnt   = 1'b0;
      r1_gnt   = 1'b0;
      lock_err = 1'b0;
      if (!reset) begin
         case (state)
            IDLE: begin
               if (r0_req && r1_req) begin
                  r0_gnt = ~rr_ptr;
                  r1_gnt = rr_ptr;
               end else begin
                  r0_gnt = r0_req;
                  r1_gnt = r1_req;
               end
            end
            OWN0: begin
               r0_gnt   = r0_req;
               lock_err = !r0_req && (lock_cnt == CNT_LAST);
            end
            OWN1: begin
               r1_gnt   = r1_req;
               lock_err = !r1_req && (lock_cnt == CNT_LAST);
            end
            default: ;
         endcase
      end
   end

   assign acc0      = r0_req & r0_gnt;
   assign acc1      = r1_req & r1_gnt;
   assign acc       = acc0 | acc1;
   assign iss_we    = acc1 ? r1_we    : r0_we;
   assign iss_addr  = acc1 ? r1_addr  : r0_addr;
   assign iss_wdata = acc1 ? r1_wdata : r0_wdata;
   assign rd_issue  = acc & ~iss_we;

   // Ownership transitions: a locked beat takes ownership, an unlocked beat or a timeout drops it.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (acc0 && r0_lock)      state_nxt = OWN0;
            else if (acc1 && r1_lock) state_nxt = OWN1;
         end
         OWN0: begin
            if (acc0)          state_nxt = r0_lock ? OWN0 : IDLE;
            else if (lock_err) state_nxt = IDLE;
         end
         OWN1: begin
            if (acc1)          state_nxt = r1_lock ? OWN1 : IDLE;
            else if (lock_err) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Ownership state register.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: clocked state is written with non-blocking assignments so every register samples pre-edge values.
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Round-robin pointer and lock idle counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr   <= 1'b0;
         lock_cnt <= '0;
      end else begin
         if (acc0)          rr_ptr <= 1'b1;
         else if (acc1)     rr_ptr <= 1'b0;
         else if (lock_err) rr_ptr <= (state == OWN0);

         if (acc || lock_err)    lock_cnt <= '0;
         else if (state != IDLE) lock_cnt <= lock_cnt + 1'b1;
      end
   end

   // Registered SRAM pins: the accepted beat appears one cycle later; idle cycles hold address/data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sram_a   <= '0;
         sram_d   <= '0;
         sram_wen <= 1'b1;
      end else begin
         sram_wen <= ~(acc & iss_we);
         if (acc) begin
            sram_a <= iss_addr;
            sram_d <= iss_wdata;
         end
      end
   end

   // Tag pipe tracking in-flight reads in issue order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_vld <= '0;
         tag_id  <= '0;
      end else begin
         tag_vld <= {tag_vld[RD_LAT-1:0], rd_issue};
         tag_id  <= {tag_id[RD_LAT-1:0], acc1};
      end
   end

   // Read return: capture sram_q for the tagged issuer and pulse its rvalid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r0_rvalid <= 1'b0;
         r1_rvalid <= 1'b0;
         r0_rdata  <= '0;
         r1_rdata  <= '0;
      end else begin
         r0_rvalid <= tag_vld[RD_LAT] & ~tag_id[RD_LAT];
         r1_rvalid <= tag_vld[RD_LAT] &  tag_id[RD_LAT];
         if (tag_vld[RD_LAT] && !tag_id[RD_LAT]) r0_rdata <= sram_q;
         if (tag_vld[RD_LAT] &&  tag_id[RD_LAT]) r1_rdata <= sram_q;
      end
   end

endmodule

// File: tb/tb_cle_sram_arb.sv
// tb_cle_sram_arb: directed scenarios followed by randomized traffic. A reference
// model predicts grants, lock timeouts and SRAM pins each cycle and queues expected
// read returns; a separate monitor pops them as the DUT presents rvalid.
module tb_cle_sram_arb;

   localparam int AW        = 10;
   localparam int DW        = 8;
   localparam int RD_LAT    = 1;
   localparam int BURST_MAX = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          r0_req, r0_we, r0_lock, r0_gnt, r0_rvalid;
   logic [AW-1:0] r0_addr;
   logic [DW-1:0] r0_wdata, r0_rdata;
   logic          r1_req, r1_we, r1_lock, r1_gnt, r1_rvalid;
   logic [AW-1:0] r1_addr;
   logic [DW-1:0] r1_wdata, r1_rdata;
   logic [AW-1:0] sram_a;
   logic [DW-1:0] sram_d;
   logic          sram_wen;
   logic [DW-1:0] sram_q;
   logic          lock_err;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   typedef struct {
      int            port;
      logic [DW-1:0] data;
      int            due;
   } exp_t;
   exp_t exp_q[$];

   cle_sram_arb #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .BURST_MAX(BURST_MAX)) dut (
      .clk(clk), .reset(reset),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_lock(r0_lock),
      .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_lock(r1_lock),
      .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
      .sram_a(sram_a), .sram_d(sram_d), .sram_wen(sram_wen), .sram_q(sram_q),
      .lock_err(lock_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] init_val(input int i);
      if (i == 'h155) return 8'h3C;
      return 8'((i * 7) ^ 'h5A);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // SRAM behavioural model: synchronous read with one cycle latency, write when sram_wen is low.
   initial begin : sram_model
      logic [DW-1:0] mem [1 << AW];
      logic [DW-1:0] q_n;
      for (int i = 0; i < (1 << AW); i++) mem[i] = init_val(i);
      sram_q = '0;
      forever begin
         @(posedge clk);
         q_n = mem[sram_a];
         if (!sram_wen) mem[sram_a] = sram_d;
         sram_q <= q_n;
      end
   end

   // Reference model: arbitration by rule, shadow memory in issue order, expected returns queued.
   initial begin : ref_model
      logic [DW-1:0] ref_mem [1 << AW];
      int            owner, wcnt, favour, g;
      logic          exp_err, we, lk;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      logic          prev_acc, prev_we;
      logic [AW-1:0] prev_addr;
      logic [DW-1:0] prev_wd;
      for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(i);
      owner = -1; wcnt = 0; favour = 0; prev_acc = 0; prev_we = 0; prev_addr = '0; prev_wd = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            owner = -1; wcnt = 0; favour = 0; prev_acc = 0;
            exp_q.delete();
         end else begin
            check("sram_wen", sram_wen, (prev_acc && prev_we) ? 0 : 1);
            if (prev_acc) begin
               check("sram_a", sram_a, prev_addr);
               if (prev_we) check("sram_d", sram_d, prev_wd);
            end
            if (owner >= 0)              g = ((owner == 0) ? r0_req : r1_req) ? owner : -1;
            else if (r0_req && r1_req)   g = favour;
            else if (r0_req)             g = 0;
            else if (r1_req)             g = 1;
            else                         g = -1;
            exp_err = (owner >= 0) && (g < 0) && (wcnt == BURST_MAX - 1);
            check("r0_gnt", r0_gnt, (g == 0) ? 1 : 0);
            check("r1_gnt", r1_gnt, (g == 1) ? 1 : 0);
            check("lock_err", lock_err, exp_err);
            if (g >= 0) begin
               we   = (g == 1) ? r1_we    : r0_we;
               addr = (g == 1) ? r1_addr  : r0_addr;
               wd   = (g == 1) ? r1_wdata : r0_wdata;
               lk   = (g == 1) ? r1_lock  : r0_lock;
               if (we) ref_mem[addr] = wd;
               else    exp_q.push_back('{g, ref_mem[addr], cyc + RD_LAT + 2});
               favour = 1 - g;
               owner  = lk ? g : -1;
               wcnt   = 0;
               prev_acc = 1; prev_we = we; prev_addr = addr; prev_wd = wd;
            end else begin
               prev_acc = 0;
               if (exp_err) begin
                  favour = 1 - owner;
                  owner  = -1;
                  wcnt   = 0;
               end else if (owner >= 0) begin
                  wcnt++;
               end
            end
         end
      end
   end

   // Monitor: pops the expected return whenever the DUT presents rvalid.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
               n_vec++; n_err++;
               $display("FAIL rvalid_missing: got none expected port %0d data %0h due cycle %0d", exp_q[0].port, exp_q[0].data, exp_q[0].due);
               void'(exp_q.pop_front());
            end
            if (r0_rvalid || r1_rvalid) begin
               check("rvalid_one_hot", r0_rvalid & r1_rvalid, 0);
               if (exp_q.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL rvalid_unexpected: got rvalid r0=%0b r1=%0b expected none (cycle %0d)", r0_rvalid, r1_rvalid, cyc);
               end else begin
                  e = exp_q.pop_front();
                  check("rvalid_port", r1_rvalid, e.port);
                  check("rdata", r1_rvalid ? r1_rdata : r0_rdata, e.data);
                  check("rvalid_cycle", cyc, e.due);
               end
            end
         end
      end
   end

   task automatic set_in(input logic q0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0, input logic l0,
                         input logic q1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1, input logic l1);
      r0_req = q0; r0_we = w0; r0_addr = a0; r0_wdata = d0; r0_lock = l0;
      r1_req = q1; r1_we = w1; r1_addr = a1; r1_wdata = d1; r1_lock = l1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      set_in(0, 0, '0, '0, 0, 0, 0, '0, '0, 0);
      repeat (n) tick();
   endtask

   task automatic check_reset_vals();
      check("rst_sram_a", sram_a, 0);
      check("rst_sram_d", sram_d, 0);
      check("rst_sram_wen", sram_wen, 1);
      check("rst_r0_gnt", r0_gnt, 0);
      check("rst_r1_gnt", r1_gnt, 0);
      check("rst_r0_rvalid", r0_rvalid, 0);
      check("rst_r1_rvalid", r1_rvalid, 0);
      check("rst_r0_rdata", r0_rdata, 0);
      check("rst_r1_rdata", r1_rdata, 0);
      check("rst_lock_err", lock_err, 0);
   endtask

   initial begin : stimulus
      int            cnt, at, first_g, p;
      logic [DW-1:0] got;
      logic [AW-1:0] ra0, ra1;
      reset = 1'b1;
      set_in(0, 0, '0, '0, 0, 0, 0, '0, '0, 0);
      repeat (2) tick();
      check_reset_vals();
      reset = 1'b0;

      // Both ports request continuously from the first cycle after reset: strict alternation.
      for (int i = 0; i < 8; i++) begin
         set_in(1, 0, 10'($urandom_range(1023)), '0, 0, 1, 0, 10'($urandom_range(1023)), '0, 0);
         #1;
         check("alt_r0_gnt", r0_gnt, (i % 2 == 0) ? 1 : 0);
         check("alt_r1_gnt", r1_gnt, (i % 2 == 1) ? 1 : 0);
         tick();
      end
      idle(5);

      // Single read of 0x155 holding 0x3C.
      set_in(1, 0, 10'h155, '0, 0, 0, 0, '0, '0, 0);
      #1;
      check("t1_gnt", r0_gnt, 1);
      tick();
      check("t1_sram_a", sram_a, 10'h155);
      check("t1_sram_wen", sram_wen, 1);
      idle(2);
      check("t1_rvalid", r0_rvalid, 1);
      check("t1_rdata", r0_rdata, 8'h3C);
      idle(4);

      // Four-beat locked burst on port 0 while port 1 waits.
      set_in(1, 0, 10'h010, '0, 1, 0, 0, '0, '0, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         set_in(1, i[0], 10'h011 + 10'(i), 8'hA0 + 8'(i), (i < 2) ? 1'b1 : 1'b0, 1, 0, 10'h020, '0, 0);
         #1;
         check("t3_r0_gnt", r0_gnt, 1);
         check("t3_r1_held", r1_gnt, 0);
         tick();
      end
      set_in(0, 0, '0, '0, 0, 1, 0, 10'h020, '0, 0);
      #1;
      check("t3_r1_after", r1_gnt, 1);
      tick();
      idle(4);

      // Abandoned lock: forced release after BURST_MAX idle cycles.
      set_in(1, 0, 10'h030, '0, 1, 0, 0, '0, '0, 0);
      tick();
      cnt = 0; at = -1; first_g = -1;
      for (int i = 0; i < 10; i++) begin
         set_in(0, 0, '0, '0, 0, 1, 0, 10'h031, '0, 0);
         #1;
         if (lock_err) begin cnt++; at = i; end
         if (r1_gnt && first_g < 0) first_g = i;
         tick();
      end
      check("t4_err_pulses", cnt, 1);
      check("t4_err_cycle", at, BURST_MAX - 1);
      check("t4_r1_gnt_cycle", first_g, BURST_MAX);
      idle(4);

      // Write then read the top address on port 1.
      cnt = 0; got = '0;
      for (int i = 0; i < 6; i++) begin
         if (i == 0)      set_in(0, 0, '0, '0, 0, 1, 1, 10'h3FF, 8'h2A, 0);
         else if (i == 1) set_in(0, 0, '0, '0, 0, 1, 0, 10'h3FF, '0, 0);
         else             set_in(0, 0, '0, '0, 0, 0, 0, '0, '0, 0);
         tick();
         if (!sram_wen) cnt++;
         if (r1_rvalid) got = r1_rdata;
      end
      check("t5_wen_low_cycles", cnt, 1);
      check("t5_r1_rdata", got, 8'h2A);
      idle(4);

      // Reset with two reads in flight.
      set_in(1, 0, 10'h040, '0, 0, 1, 0, 10'h041, '0, 0);
      tick();
      tick();
      set_in(0, 0, '0, '0, 0, 0, 0, '0, '0, 0);
      #1 reset = 1'b1;
      #1 check_reset_vals();
      tick();
      tick();
      reset = 1'b0;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (r0_rvalid || r1_rvalid) cnt++;
      end
      check("t6_no_stale_rvalid", cnt, 0);
      set_in(1, 0, 10'h155, '0, 0, 0, 0, '0, '0, 0);
      #1;
      check("t6_gnt_after_reset", r0_gnt, 1);
      tick();
      idle(5);

      // Randomized traffic with varying request density to exercise lock timeouts and hazards.
      for (int seg = 0; seg < 15; seg++) begin
         case ($urandom_range(2))
            0:       p = 20;
            1:       p = 50;
            default: p = 90;
         endcase
         for (int i = 0; i < 200; i++) begin
            ra0 = ($urandom_range(1) == 1) ? 10'($urandom_range(7)) : 10'($urandom_range(1023));
            ra1 = ($urandom_range(1) == 1) ? 10'($urandom_range(7)) : 10'($urandom_range(1023));
            set_in(($urandom_range(99) < p) ? 1'b1 : 1'b0, ($urandom_range(3) == 0) ? 1'b1 : 1'b0, ra0,
                   8'($urandom_range(255)), ($urandom_range(2) == 0) ? 1'b1 : 1'b0,
                   ($urandom_range(99) < p) ? 1'b1 : 1'b0, ($urandom_range(3) == 0) ? 1'b1 : 1'b0, ra1,
                   8'($urandom_range(255)), ($urandom_range(2) == 0) ? 1'b1 : 1'b0);
            tick();
         end
      end
      idle(12);

      if (exp_q.size() != 0) begin
         n_vec++; n_err++;
         $display("FAIL drain: got %0d reads outstanding expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
